// File: rtl/motoro3_pwm_len_seq.sv
// PWM length lookup and period counter for 6-step commutation.
// Step/mode/period are double-buffered and only take effect at a period wrap.
module motoro3_pwm_len_seq #(
  parameter int          LEN_W    = 16,
  parameter int          STEP_W   = 4,
  parameter int          MAX_STEP = 6,
  parameter int unsigned L6       = 17560,
  parameter int unsigned L12      = 8628,
  parameter int unsigned L24      = 4295
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_vld,
  input  logic [STEP_W-1:0] step_in,
  input  logic [1:0]        mode_in,
  input  logic [LEN_W-1:0]  slLen,
  output logic [LEN_W-1:0]  plLen,
  output logic [2:0]        pwm_hi,
  output logic [2:0]        en_lo,
  output logic              wrap
);

  logic [LEN_W-1:0] lk_len;
  logic [2:0]       lk_hi, lk_lo;

  logic [LEN_W-1:0] pend_len;
  logic [2:0]       pend_hi, pend_lo;

  logic [LEN_W-1:0] cnt, per_act;
  logic [2:0]       act_hi, act_lo;

  logic             roll;
  logic [LEN_W-1:0] nxt_cnt, nxt_per, nxt_pl;
  logic [2:0]       nxt_hi, nxt_lo;

  // Invalid step or mode 3 resolves to coast with zero length.
  always_comb begin
    lk_len = '0;
    lk_hi  = 3'b000;
    lk_lo  = 3'b000;
    if (mode_in != 2'd3 && step_in != '0 && step_in <= STEP_W'(MAX_STEP)) begin
      case (mode_in)
        2'd0:    lk_len = LEN_W'(L6);
        2'd1:    lk_len = LEN_W'(L12);
        default: lk_len = LEN_W'(L24);
      endcase
      case (step_in)
        STEP_W'(1): begin lk_hi = 3'b001; lk_lo = 3'b010; end
        STEP_W'(2): begin lk_hi = 3'b001; lk_lo = 3'b100; end
        STEP_W'(3): begin lk_hi = 3'b010; lk_lo = 3'b100; end
        STEP_W'(4): begin lk_hi = 3'b010; lk_lo = 3'b001; end
        STEP_W'(5): begin lk_hi = 3'b100; lk_lo = 3'b001; end
        STEP_W'(6): begin lk_hi = 3'b100; lk_lo = 3'b010; end
        default:    begin lk_hi = 3'b000; lk_lo = 3'b000; lk_len = '0; end
      endcase
    end
  end

  // An idle counter (per_act == 0) rolls every cycle so the shadows keep tracking.
  always_comb begin
    roll    = (per_act == '0) || (cnt == per_act - LEN_W'(1));
    nxt_cnt = cnt + LEN_W'(1);
    nxt_per = per_act;
    nxt_pl  = plLen;
    nxt_hi  = act_hi;
    nxt_lo  = act_lo;
    if (roll) begin
      nxt_cnt = '0;
      nxt_per = slLen;
      nxt_pl  = (pend_len < slLen) ? pend_len : slLen;
      nxt_hi  = pend_hi;
      nxt_lo  = pend_lo;
    end
  end

  // Outputs are computed from next state so they line up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_len <= '0;
      pend_hi  <= 3'b000;
      pend_lo  <= 3'b000;
      cnt      <= '0;
      per_act  <= '0;
      plLen    <= '0;
      act_hi   <= 3'b000;
      act_lo   <= 3'b000;
      pwm_hi   <= 3'b000;
      en_lo    <= 3'b000;
      wrap     <= 1'b0;
    end else begin
      if (step_vld) begin
        pend_len <= lk_len;
        pend_hi  <= lk_hi;
        pend_lo  <= lk_lo;
      end
      cnt     <= nxt_cnt;
      per_act <= nxt_per;
      plLen   <= nxt_pl;
      act_hi  <= nxt_hi;
      act_lo  <= nxt_lo;
      pwm_hi  <= (nxt_per != '0 && nxt_cnt < nxt_pl) ? nxt_hi : 3'b000;
      en_lo   <= (nxt_per != '0) ? nxt_lo : 3'b000;
      wrap    <= (nxt_per != '0) && (nxt_cnt == nxt_per - LEN_W'(1));
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_len_seq.sv
// Directed bench for motoro3_pwm_len_seq: lookup, period timing, clamp,
// double-buffered updates, invalid inputs and mid-period reset.
module tb_motoro3_pwm_len_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_vld;
  logic [3:0]  step_in;
  logic [1:0]  mode_in;
  logic [15:0] slLen;
  logic [15:0] plLen;
  logic [2:0]  pwm_hi;
  logic [2:0]  en_lo;
  logic        wrap;

  int n_cmp = 0;
  int n_err = 0;

  motoro3_pwm_len_seq dut (
    .clk(clk), .rst(rst), .step_vld(step_vld), .step_in(step_in),
    .mode_in(mode_in), .slLen(slLen), .plLen(plLen),
    .pwm_hi(pwm_hi), .en_lo(en_lo), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst === 1'b0)
      assert ((pwm_hi & en_lo) == 3'b000)
      else $error("FAIL shoot_through hi=%b lo=%b", pwm_hi, en_lo);

  task test_reset;
    rst = 1'b1; step_vld = 1'b0; step_in = 4'd0; mode_in = 2'd0; slLen = 16'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pwm_hi !== 3'b000) begin n_err++; $display("FAIL rst_pwm_hi got %b want 000", pwm_hi); end
    n_cmp++; if (en_lo !== 3'b000) begin n_err++; $display("FAIL rst_en_lo got %b want 000", en_lo); end
    n_cmp++; if (plLen !== 16'd0) begin n_err++; $display("FAIL rst_plLen got %0d want 0", plLen); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL rst_wrap got %b want 0", wrap); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (wrap !== 1'b0 || plLen !== 16'd0) begin n_err++; $display("FAIL idle_after_rst wrap=%b plLen=%0d want 0/0", wrap, plLen); end
  endtask

  task test_basic_period;
    int hi_cnt, first_lo, n_wrap, wrap_at, lo_bad;
    @(negedge clk); step_vld = 1'b1; step_in = 4'd1; mode_in = 2'd0;
    @(negedge clk); step_vld = 1'b0; slLen = 16'd20000;
    hi_cnt = 0; first_lo = -1; n_wrap = 0; wrap_at = -1; lo_bad = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (pwm_hi === 3'b001) hi_cnt++;
      else if (first_lo < 0) first_lo = k;
      if (wrap === 1'b1) begin n_wrap++; wrap_at = k; end
      if (en_lo !== 3'b010) lo_bad++;
    end
    n_cmp++; if (plLen !== 16'd17560) begin n_err++; $display("FAIL t2_plLen got %0d want 17560", plLen); end
    n_cmp++; if (hi_cnt != 17560) begin n_err++; $display("FAIL t2_on_cycles got %0d want 17560", hi_cnt); end
    n_cmp++; if (first_lo != 17560) begin n_err++; $display("FAIL t2_first_off got %0d want 17560", first_lo); end
    n_cmp++; if (n_wrap != 1 || wrap_at != 19999) begin n_err++; $display("FAIL t2_wrap count=%0d at=%0d want 1/19999", n_wrap, wrap_at); end
    n_cmp++; if (lo_bad != 0) begin n_err++; $display("FAIL t2_en_lo bad_cycles=%0d want 0", lo_bad); end
  endtask

  task test_mid_update;
    int k;
    repeat (101) @(negedge clk);
    step_vld = 1'b1; step_in = 4'd3; mode_in = 2'd1;
    @(negedge clk); step_vld = 1'b0;
    n_cmp++; if (en_lo !== 3'b010 || plLen !== 16'd17560) begin n_err++; $display("FAIL t5_hold en_lo=%b plLen=%0d want 010/17560", en_lo, plLen); end
    k = 101;
    while (wrap !== 1'b1 && k < 20100) begin @(negedge clk); k++; end
    n_cmp++; if (k != 19999) begin n_err++; $display("FAIL t5_wrap_pos got %0d want 19999", k); end
    n_cmp++; if (en_lo !== 3'b010 || plLen !== 16'd17560) begin n_err++; $display("FAIL t5_hold_at_wrap en_lo=%b plLen=%0d want 010/17560", en_lo, plLen); end
    @(negedge clk);
    n_cmp++; if (plLen !== 16'd8628) begin n_err++; $display("FAIL t5_new_plLen got %0d want 8628", plLen); end
    n_cmp++; if (pwm_hi !== 3'b010 || en_lo !== 3'b100) begin n_err++; $display("FAIL t5_new_phase hi=%b lo=%b want 010/100", pwm_hi, en_lo); end
  endtask

  task test_reset_mid;
    repeat (9000) @(negedge clk);
    n_cmp++; if (en_lo !== 3'b100) begin n_err++; $display("FAIL t6_pre_rst en_lo got %b want 100", en_lo); end
    rst = 1'b1; slLen = 16'd0;
    @(negedge clk);
    n_cmp++; if (pwm_hi !== 3'b000 || en_lo !== 3'b000 || plLen !== 16'd0 || wrap !== 1'b0) begin
      n_err++; $display("FAIL t6_rst_mid hi=%b lo=%b plLen=%0d wrap=%b want all 0", pwm_hi, en_lo, plLen, wrap);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (en_lo !== 3'b000 || plLen !== 16'd0) begin n_err++; $display("FAIL t6_after_rst lo=%b plLen=%0d want 000/0", en_lo, plLen); end
  endtask

  task test_step_walk;
    logic [2:0] hi_e [1:6];
    logic [2:0] lo_e [1:6];
    int hi_cnt, n_wrap, wrap_at, bad;
    hi_e[1] = 3'b001; lo_e[1] = 3'b010;
    hi_e[2] = 3'b001; lo_e[2] = 3'b100;
    hi_e[3] = 3'b010; lo_e[3] = 3'b100;
    hi_e[4] = 3'b010; lo_e[4] = 3'b001;
    hi_e[5] = 3'b100; lo_e[5] = 3'b001;
    hi_e[6] = 3'b100; lo_e[6] = 3'b010;
    @(negedge clk); step_vld = 1'b1; step_in = 4'd1; mode_in = 2'd2;
    @(negedge clk); step_vld = 1'b0; slLen = 16'd5000;
    for (int p = 1; p <= 6; p++) begin
      hi_cnt = 0; n_wrap = 0; wrap_at = -1; bad = 0;
      for (int k = 0; k < 5000; k++) begin
        @(negedge clk);
        if (k == 0) begin
          n_cmp++; if (pwm_hi !== hi_e[p] || en_lo !== lo_e[p]) begin
            n_err++; $display("FAIL t3_phase step%0d hi=%b lo=%b want %b/%b", p, pwm_hi, en_lo, hi_e[p], lo_e[p]);
          end
          n_cmp++; if (plLen !== 16'd4295) begin n_err++; $display("FAIL t3_plLen step%0d got %0d want 4295", p, plLen); end
        end
        if (pwm_hi === hi_e[p]) hi_cnt++;
        else if (pwm_hi !== 3'b000) bad++;
        if (en_lo !== lo_e[p]) bad++;
        if (wrap === 1'b1) begin n_wrap++; wrap_at = k; end
        if (k == 10 && p < 6) begin step_vld = 1'b1; step_in = 4'(p + 1); mode_in = 2'd2; end
        if (k == 11) step_vld = 1'b0;
        if (p == 6 && k == 3000) slLen = 16'd0;
      end
      n_cmp++; if (hi_cnt != 4295) begin n_err++; $display("FAIL t3_on_cycles step%0d got %0d want 4295", p, hi_cnt); end
      n_cmp++; if (n_wrap != 1 || wrap_at != 4999) begin n_err++; $display("FAIL t3_wrap step%0d count=%0d at=%0d want 1/4999", p, n_wrap, wrap_at); end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL t3_stray step%0d bad_cycles=%0d want 0", p, bad); end
    end
    @(negedge clk);
    n_cmp++; if (pwm_hi !== 3'b000 || en_lo !== 3'b000 || wrap !== 1'b0) begin
      n_err++; $display("FAIL t3_stop hi=%b lo=%b wrap=%b want 000/000/0", pwm_hi, en_lo, wrap);
    end
  endtask

  task test_clamp;
    int hi_cnt, n_wrap, wrap_at, bad;
    @(negedge clk); step_vld = 1'b1; step_in = 4'd1; mode_in = 2'd0;
    @(negedge clk); step_vld = 1'b0; slLen = 16'd8000;
    hi_cnt = 0; n_wrap = 0; wrap_at = -1;
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if (plLen !== 16'd8000) begin n_err++; $display("FAIL t4_clamp_plLen got %0d want 8000", plLen); end
      end
      if (pwm_hi === 3'b001) hi_cnt++;
      if (wrap === 1'b1) begin n_wrap++; wrap_at = k; end
      if (k == 100) slLen = 16'd0;
    end
    n_cmp++; if (hi_cnt != 8000) begin n_err++; $display("FAIL t4_full_on got %0d want 8000", hi_cnt); end
    n_cmp++; if (n_wrap != 1 || wrap_at != 7999) begin n_err++; $display("FAIL t4_wrap count=%0d at=%0d want 1/7999", n_wrap, wrap_at); end
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (pwm_hi !== 3'b000 || en_lo !== 3'b000 || wrap !== 1'b0 || plLen !== 16'd0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL t4_coast bad_cycles=%0d want 0", bad); end
  endtask

  task test_invalid;
    int n_wrap, wrap_at, bad;
    @(negedge clk); step_vld = 1'b1; step_in = 4'd7; mode_in = 2'd0;
    @(negedge clk); step_vld = 1'b0; slLen = 16'd50;
    for (int p = 0; p < 2; p++) begin
      n_wrap = 0; wrap_at = -1; bad = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (pwm_hi !== 3'b000 || en_lo !== 3'b000 || plLen !== 16'd0) bad++;
        if (wrap === 1'b1) begin n_wrap++; wrap_at = k; end
        if (p == 0 && k == 20) begin step_vld = 1'b1; step_in = 4'd2; mode_in = 2'd3; end
        if (k == 21) step_vld = 1'b0;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL t6_invalid_coast pass%0d bad_cycles=%0d want 0", p, bad); end
      n_cmp++; if (n_wrap != 1 || wrap_at != 49) begin n_err++; $display("FAIL t6_invalid_wrap pass%0d count=%0d at=%0d want 1/49", p, n_wrap, wrap_at); end
    end
  endtask

  task test_back_to_back;
    int n;
    @(negedge clk); step_vld = 1'b1; step_in = 4'd4; mode_in = 2'd0;
    @(negedge clk); step_vld = 1'b1; step_in = 4'd5; mode_in = 2'd2;
    @(negedge clk); step_vld = 1'b0;
    n = 0;
    while (wrap !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (wrap !== 1'b1) begin n_err++; $display("FAIL b2b_wrap_timeout got %b want 1", wrap); end
    step_vld = 1'b1; step_in = 4'd6; mode_in = 2'd0;
    @(negedge clk); step_vld = 1'b0;
    n_cmp++; if (pwm_hi !== 3'b100 || en_lo !== 3'b001) begin n_err++; $display("FAIL b2b_last_wins hi=%b lo=%b want 100/001", pwm_hi, en_lo); end
    n_cmp++; if (plLen !== 16'd50) begin n_err++; $display("FAIL b2b_plLen got %0d want 50", plLen); end
    n = 0;
    while (wrap !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (n != 49) begin n_err++; $display("FAIL defer_wrap_pos got %0d want 49", n); end
    @(negedge clk);
    n_cmp++; if (pwm_hi !== 3'b100 || en_lo !== 3'b010) begin n_err++; $display("FAIL defer_applied hi=%b lo=%b want 100/010", pwm_hi, en_lo); end
  endtask

  initial begin
    test_reset;
    test_basic_period;
    test_mid_update;
    test_reset_mid;
    test_step_walk;
    test_clamp;
    test_invalid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
